// File: rtl/cam_stream_gen.sv
// cam_stream_gen: synthetic TVP5150-style luma stream source with selectable test patterns
// Ports: cam_pclk/cam_resetn (sync, active-low), enable (checked at field boundaries),
//   pattern_sel (0 H ramp, 1 V ramp, 2 checker, 3 field counter; latched at field start),
//   line_valid, y_valid, y, field_toggle, busy -- all registered.
// Optional: define CAM_GEN_ODD_EXTRA_LINE_EN to add one blank line to fields where field_toggle becomes 1.
module cam_stream_gen #(
  parameter int ACTIVE_PIX    = 720,
  parameter int ACTIVE_LINES  = 288,
  parameter int H_BLANK       = 276,
  parameter int V_BLANK_LINES = 25
) (
  input  logic       cam_pclk,
  input  logic       cam_resetn,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       line_valid,
  output logic       y_valid,
  output logic [7:0] y,
  output logic       field_toggle,
  output logic       busy
);
  localparam int LINE = 2*ACTIVE_PIX + H_BLANK;
  localparam int VB_MAX = (V_BLANK_LINES + 1) * LINE;
  localparam int BW = $clog2(VB_MAX + 1) > 16 ? $clog2(VB_MAX + 1) : 16;
  typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE, HBLANK} state_t;
  state_t state, state_d;
  logic [10:0] phase;
  logic [9:0] line_idx;
  logic [BW-1:0] cnt, vb_len;
  logic [1:0] pat;
  logic [7:0] field_cnt, pix, y_d;
  logic tog, started, field_start, line_last, hb_done, vb_done, act_done, lv_d, yv_d;
`ifdef CAM_GEN_ODD_EXTRA_LINE_EN
  assign vb_len = tog ? BW'((V_BLANK_LINES + 1) * LINE) : BW'(V_BLANK_LINES * LINE);
`else
  assign vb_len = BW'(V_BLANK_LINES * LINE);
`endif
  assign line_last = line_idx == 10'(ACTIVE_LINES - 1);
  assign hb_done = cnt == BW'(H_BLANK - 1);
  assign vb_done = cnt == vb_len - 1'b1;
  assign act_done = phase == 11'(2*ACTIVE_PIX - 1);
  assign field_start = enable && (state == IDLE || (state == HBLANK && hb_done && line_last));
  always_ff @(posedge cam_pclk) begin
    if (!cam_resetn) begin
      state <= IDLE;
      cnt <= '0;
      phase <= '0;
      line_idx <= '0;
      pat <= '0;
      field_cnt <= '0;
      tog <= 1'b0;
      started <= 1'b0;
      line_valid <= 1'b0;
      y_valid <= 1'b0;
      y <= '0;
      field_toggle <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= (state_d == state && (state == VBLANK || state == HBLANK)) ? cnt + 1'b1 : '0;
      phase <= (state == ACTIVE && !act_done) ? phase + 1'b1 : '0;
      if (field_start) begin
        tog <= ~tog;
        pat <= pattern_sel;
        line_idx <= '0;
        started <= 1'b1;
        if (started) field_cnt <= field_cnt + 1'b1;
      end else if (state == HBLANK && hb_done) begin
        line_idx <= line_idx + 1'b1;
      end
      line_valid <= lv_d;
      y_valid <= yv_d;
      y <= y_d;
      field_toggle <= tog;
      busy <= state != IDLE;
    end
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = enable ? VBLANK : IDLE;
      VBLANK:  state_d = vb_done ? ACTIVE : VBLANK;
      ACTIVE:  state_d = act_done ? HBLANK : ACTIVE;
      HBLANK:  state_d = !hb_done ? HBLANK : !line_last ? ACTIVE : enable ? VBLANK : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Odd phases carry luma; the preceding even phase is the chroma slot.
  always_comb begin
    pix = phase[8:1];
    lv_d = state == ACTIVE;
    yv_d = lv_d && phase[0];
    y_d = !yv_d ? y :
          pat == 2'd0 ? pix :
          pat == 2'd1 ? line_idx[7:0] :
          pat == 2'd2 ? ((pix[3] ^ line_idx[3]) ? 8'd235 : 8'd16) :
          field_cnt;
  end
endmodule

// File: tb/tb_cam_stream_gen.sv
// tb_cam_stream_gen: directed timeline checks for cam_stream_gen with a 4-pixel, 3-line, 10-cycle-line setup
module tb_cam_stream_gen;
`ifdef CAM_GEN_ODD_EXTRA_LINE_EN
  localparam int F1 = 31, E1 = 60;
`else
  localparam int F1 = 21, E1 = 50;
`endif
  localparam int T2 = E1 + 1;
  localparam int N = 200;
  logic clk = 1'b0, cam_resetn = 1'b0, enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic line_valid, y_valid, field_toggle, busy;
  logic [7:0] y;
  logic lv_r [0:N-1], yv_r [0:N-1], tg_r [0:N-1], bz_r [0:N-1];
  logic [7:0] y_r [0:N-1];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  cam_stream_gen #(.ACTIVE_PIX(4), .ACTIVE_LINES(3), .H_BLANK(2), .V_BLANK_LINES(2)) dut (
    .cam_pclk(clk), .cam_resetn(cam_resetn), .enable(enable), .pattern_sel(pattern_sel),
    .line_valid(line_valid), .y_valid(y_valid), .y(y), .field_toggle(field_toggle), .busy(busy)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    cam_resetn = 1'b0;
    enable = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic run(input int n, input int rst_at, input int en_off, input int en_on,
                     input int pat0, input int pat1, input int pat_at);
    for (int c = 0; c < n; c++) begin
      cam_resetn = (c == rst_at) ? 1'b0 : 1'b1;
      enable = (c >= en_off && c < en_on) ? 1'b0 : 1'b1;
      pattern_sel = (c >= pat_at) ? 2'(pat1) : 2'(pat0);
      @(posedge clk);
      #1;
      lv_r[c] = line_valid;
      yv_r[c] = y_valid;
      tg_r[c] = field_toggle;
      bz_r[c] = busy;
      y_r[c] = y;
    end
  endtask
  function automatic bit in_line(input int c, input int first);
    return c >= first && c - first < 30 && (c - first) % 10 < 8;
  endfunction
  initial begin
    int start, v;
    do_reset();
    chk("rst_lv", int'(line_valid), 0);
    chk("rst_yv", int'(y_valid), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_tg", int'(field_toggle), 0);
    chk("rst_busy", int'(busy), 0);
    run(120, -1, N, N, 0, 0, N);
    chk("s1_busy0", int'(bz_r[0]), 0);
    chk("s1_busy1", int'(bz_r[1]), 1);
    chk("s1_tg0", int'(tg_r[0]), 0);
    chk("s1_tg1", int'(tg_r[1]), 1);
    chk("s1_tg_end", int'(tg_r[T2-1]), 1);
    chk("s1_tg2", int'(tg_r[T2]), 0);
    chk("s1_tg3", int'(tg_r[T2+49]), 0);
    chk("s1_tg3b", int'(tg_r[T2+50]), 1);
    for (int c = 0; c < T2; c++) begin
      chk($sformatf("s1_lv@%0d", c), int'(lv_r[c]), int'(in_line(c, F1)));
      chk($sformatf("s1_yv@%0d", c), int'(yv_r[c]), int'(in_line(c, F1) && (c - F1) % 2 == 1));
    end
    for (int k = 0; k < 4; k++) chk($sformatf("s1_y%0d", k), int'(y_r[F1+1+2*k]), k);
    chk("s1_f2_lv_pre", int'(lv_r[T2+19]), 0);
    chk("s1_f2_lv", int'(lv_r[T2+20]), 1);
    do_reset();
    run(60 + F1, -1, N, N, 1, 1, N);
    for (int l = 0; l < 3; l++)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("s2_yv_l%0d_%0d", l, k), int'(yv_r[F1+1+10*l+2*k]), 1);
        chk($sformatf("s2_y_l%0d_%0d", l, k), int'(y_r[F1+1+10*l+2*k]), l);
      end
    do_reset();
    run(170, -1, N, N, 3, 3, N);
    start = 0;
    for (int f = 0; f < 3; f++) begin
`ifdef CAM_GEN_ODD_EXTRA_LINE_EN
      v = (f % 2 == 0) ? 30 : 20;
`else
      v = 20;
`endif
      chk($sformatf("s3_yv_f%0d", f), int'(yv_r[start+v+2]), 1);
      chk($sformatf("s3_y_f%0d", f), int'(y_r[start+v+2]), f);
      start += v + 30;
    end
    do_reset();
    run(E1 + 45, -1, 25, E1 + 10, 0, 0, N);
    chk("s4_line2", int'(lv_r[F1+10]), 1);
    chk("s4_line3", int'(lv_r[F1+20]), 1);
    chk("s4_line3_y", int'(y_r[F1+27]), 3);
    chk("s4_busy_end", int'(bz_r[E1]), 1);
    chk("s4_idle_busy", int'(bz_r[E1+1]), 0);
    chk("s4_idle_tg", int'(tg_r[E1+1]), 1);
    chk("s4_idle_tg5", int'(tg_r[E1+5]), 1);
    chk("s4_idle_lv", int'(lv_r[E1+5]), 0);
    chk("s4_re_tg_pre", int'(tg_r[E1+10]), 1);
    chk("s4_re_tg", int'(tg_r[E1+11]), 0);
    chk("s4_re_busy", int'(bz_r[E1+11]), 1);
    chk("s4_re_lv_pre", int'(lv_r[E1+30]), 0);
    chk("s4_re_lv", int'(lv_r[E1+31]), 1);
    do_reset();
    run(34 + F1 + 10, 33, N, N, 0, 0, N);
    chk("s5_pre_lv", int'(lv_r[32]), 1);
    chk("s5_lv", int'(lv_r[34]), 0);
    chk("s5_yv", int'(yv_r[34]), 0);
    chk("s5_y", int'(y_r[34]), 0);
    chk("s5_tg", int'(tg_r[34]), 0);
    chk("s5_busy", int'(bz_r[34]), 0);
    chk("s5_tg_re", int'(tg_r[35]), 1);
    chk("s5_busy_re", int'(bz_r[35]), 1);
    chk("s5_lv_pre", int'(lv_r[34+F1-1]), 0);
    chk("s5_lv_re", int'(lv_r[34+F1]), 1);
    chk("s5_y_re", int'(y_r[34+F1+3]), 1);
    do_reset();
    run(T2 + 50, -1, N, N, 0, 2, 30);
    for (int k = 0; k < 4; k++) chk($sformatf("s6_f1_y%0d", k), int'(y_r[F1+11+2*k]), k);
    for (int l = 0; l < 3; l++)
      for (int k = 0; k < 4; k++)
        chk($sformatf("s6_f2_y_l%0d_%0d", l, k), int'(y_r[T2+21+10*l+2*k]), 16);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end
endmodule
